instr_issue_queue: RTL and testbench

- Producer end of the fetch interface. Captures 8-bit instructions from board switches on a push-button pulse and buffers them in a FIFO.
- Presents the head instruction to the fetch stage, which samples it on every clock edge where its stall input is low.
- When the FIFO is empty it presents a NOP bubble, so the pipeline only advances on real instructions.

---
 rtl/cpu_isa_pkg.sv | 34 +++
 rtl/btn_pulse_sync.sv | 44 ++++
 rtl/instr_issue_queue.sv | 105 ++++++++++
 tb/tb_instr_issue_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - shared instruction-set constants and field layout
package cpu_isa_pkg;

  localparam int INSTR_W = 8;

  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR = 8'h00;

  // Field bit positions within an instruction word
  localparam int MODE_BIT = 7;
  localparam int OPC_HI   = 6;
  localparam int OPC_LO   = 4;
  localparam int RD_HI    = 3;
  localparam int RD_LO    = 2;
  localparam int RS_HI    = 1;
  localparam int RS_LO    = 0;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_INC = 3'b011;

  typedef struct packed {
    logic       mode;
    logic [2:0] opc;
    logic [1:0] rd;
    logic [1:0] rs;
  } instr_fields_t;

  function automatic logic [2:0] instr_opcode(input instr_t instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/btn_pulse_sync.sv
// rtl/btn_pulse_sync.sv - push-button synchronizer with one-cycle rising-edge pulse
module btn_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic pulse_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // Shift of ones marking how many clocks have elapsed since reset; the top
  // bit says edge_q now holds a genuinely sampled button level rather than
  // the reset value, so a button held through reset never looks like a press.
  logic [SYNC_STAGES:0]   prime_q, prime_d;
  logic                   edge_q, edge_d;
  logic                   pulse_q, pulse_d;

  // Next-state: shift synchronizer, remember last synchronized level, detect 0->1
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    prime_d = {prime_q[SYNC_STAGES-1:0], 1'b1};
    edge_d  = sync_q[SYNC_STAGES-1];
    pulse_d = prime_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      prime_q <= '0;
      edge_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prime_q <= prime_d;
      edge_q  <= edge_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_out = pulse_q;

endmodule

// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - button-fed instruction FIFO presenting head or NOP to fetch
module instr_issue_queue
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_btn,
  input  logic [7:0]        push_instr,
  input  logic              flush,
  input  logic              stall,
  output logic [7:0]        issue_instr,
  output logic              issue_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic              push, pop, wr_en;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  instr_t            mem_q [DEPTH];

  btn_pulse_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_push_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (push_btn),
    .pulse_out(push)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  // An empty queue under no stall hands out a NOP and changes nothing.
  assign pop   = ~stall & ~empty;

  // Pointer/count/overflow next-state; flush wins, then push+pop, push, pop
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (push && pop) begin
      // Slot being read frees up this edge, so this works even when full.
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else if (push) begin
      if (!full) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  // Control state, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset because empty masks them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_instr;
    end
  end

  // Registered head is shown directly: a write becomes visible the next cycle.
  assign issue_instr = empty ? NOP_INSTR : mem_q[rd_ptr_q];
  assign issue_valid = ~empty;
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// tb/tb_instr_issue_queue.sv - self-checking bench for instr_issue_queue
module tb_instr_issue_queue;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       push_btn = 1'b0;
  logic [7:0] push_instr = 8'h00;
  logic       flush = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] issue_instr;
  logic       issue_valid;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  // Reference model: contents as a plain queue, sticky overflow, and the
  // button level seen at each clock edge since reset was released.
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         bh[$];

  typedef struct {
    logic       btn;
    logic [7:0] instr;
    logic       st;
    logic       fl;
    int         e_count;
    logic [7:0] e_issue;
    logic       e_valid;
  } vec_t;

  vec_t tbl[32];

  always #5 clk = ~clk;

  instr_issue_queue #(
    .DEPTH(8),
    .ADDR_W(3),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .push_btn   (push_btn),
    .push_instr (push_instr),
    .flush      (flush),
    .stall      (stall),
    .issue_instr(issue_instr),
    .issue_valid(issue_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A press is recognised at the edge three edges after the first edge
  // that saw the button high, provided the edge before that saw it low
  // (and that edge happened after reset).
  task automatic model_edge();
    int n;
    bit p;
    bit pp;
    bh.push_back(push_btn);
    n = bh.size();
    p = (n >= 5) && bh[n-4] && !bh[n-5];
    pp = !stall && (mq.size() > 0);
    if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (p && pp) begin
      void'(mq.pop_front());
      mq.push_back(push_instr);
    end else if (p) begin
      if (mq.size() < DEPTH) mq.push_back(push_instr);
      else m_ovf = 1'b1;
    end else if (pp) begin
      void'(mq.pop_front());
    end
  endtask

  task automatic check_model();
    logic [7:0] e_issue;
    e_issue = (mq.size() > 0) ? mq[0] : 8'h00;
    chk("model_issue", issue_instr, e_issue);
    chk("model_valid", issue_valid, mq.size() > 0);
    chk("model_count", count, mq.size());
    chk("model_full", full, mq.size() == DEPTH);
    chk("model_empty", empty, mq.size() == 0);
    chk("model_overflow", overflow, m_ovf);
  endtask

  // Drive inputs at a negedge, let one rising edge happen, check at next negedge
  task automatic cyc(input logic btn, input logic [7:0] instr, input logic st, input logic fl);
    push_btn = btn;
    push_instr = instr;
    stall = st;
    flush = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic press(input logic [7:0] instr, input logic st);
    for (int i = 0; i < 4; i++) cyc(1'b1, instr, st, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, instr, st, 1'b0);
  endtask

  initial begin
    logic cur_btn;

    // Table: hold button 20 cycles with 1B, release, then press again with 00
    for (int i = 0; i < 32; i++) begin
      tbl[i].btn     = (i < 20) || (i >= 24 && i < 30);
      tbl[i].instr   = (i < 24) ? 8'h1B : 8'h00;
      tbl[i].st      = 1'b0;
      tbl[i].fl      = 1'b0;
      tbl[i].e_count = (i == 3 || i == 27) ? 1 : 0;
      tbl[i].e_issue = (i == 3) ? 8'h1B : 8'h00;
      tbl[i].e_valid = (i == 3 || i == 27);
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_issue", issue_instr, 8'h00);
    chk("rst_valid", issue_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 1'b0);
    resetn = 1'b1;

    // Idle with stall low
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_issue", issue_instr, 8'h00);
      chk("idle_valid", issue_valid, 1'b0);
      chk("idle_empty", empty, 1'b1);
      chk("idle_count", count, 0);
    end

    for (int i = 0; i < 32; i++) begin
      cyc(tbl[i].btn, tbl[i].instr, tbl[i].st, tbl[i].fl);
      chk("tbl_count", count, tbl[i].e_count);
      chk("tbl_issue", issue_instr, tbl[i].e_issue);
      chk("tbl_valid", issue_valid, tbl[i].e_valid);
    end

    // Stalled accumulation then release
    press(8'h11, 1'b1);
    press(8'h31, 1'b1);
    press(8'h1E, 1'b1);
    chk("stall_count", count, 3);
    chk("stall_head", issue_instr, 8'h11);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("release_1", issue_instr, 8'h31);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("release_2", issue_instr, 8'h1E);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("release_nop", issue_instr, 8'h00);
    chk("release_valid", issue_valid, 1'b0);

    // Overflow: nine pushes into eight slots, drain, refill, drain
    for (int i = 0; i < 9; i++) press(8'h40 + 8'(i), 1'b1);
    chk("ovf_full", full, 1'b1);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain1_order", issue_instr, 8'h40 + 8'(i));
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("drain1_empty", empty, 1'b1);
    chk("drain1_ovf_sticky", overflow, 1'b1);
    for (int i = 0; i < 8; i++) press(8'h50 + 8'(i), 1'b1);
    chk("refill_full", full, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("drain2_order", issue_instr, 8'h50 + 8'(i));
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("drain2_empty", empty, 1'b1);

    // Flush with a simultaneous push
    press(8'h71, 1'b1);
    press(8'h72, 1'b1);
    press(8'h73, 1'b1);
    chk("preflush_count", count, 3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h77, 1'b1, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    chk("flush_count", count, 0);
    chk("flush_ovf", overflow, 1'b0);
    chk("flush_issue", issue_instr, 8'h00);
    chk("flush_valid", issue_valid, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_nopush", count, 0);

    // Full queue: push and pop on the same edge
    for (int i = 0; i < 8; i++) press(8'h60 + 8'(i), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("pp_count", count, 8);
    chk("pp_full", full, 1'b1);
    chk("pp_ovf", overflow, 1'b0);
    chk("pp_head", issue_instr, 8'h61);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("pp_drain", issue_instr, (i < 7) ? 8'h61 + 8'(i) : 8'h3C);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("pp_empty", empty, 1'b1);

    // Asynchronous reset mid-burst with the button held through it
    press(8'hA1, 1'b1);
    press(8'hA2, 1'b1);
    cyc(1'b1, 8'hA3, 1'b1, 1'b0);
    cyc(1'b1, 8'hA3, 1'b1, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_valid", issue_valid, 1'b0);
    chk("arst_issue", issue_instr, 8'h00);
    mq.delete();
    m_ovf = 1'b0;
    bh.delete();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'hA3, 1'b1, 1'b0);
      chk("held_nopush", count, 0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'hA4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA4, 1'b1, 1'b0);
    chk("repress_count", count, 1);
    chk("repress_head", issue_instr, 8'hA4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("repress_drain", empty, 1'b1);

    // Randomised traffic against the model
    cur_btn = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cur_btn = ~cur_btn;
      cyc(cur_btn, 8'($urandom), ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
